// File: rtl/ps2_paddle_keys.sv
// ---------------------------------------------------------------------------
// ps2_paddle_keys
//
// Purpose: decodes PS/2 set-2 scan-code bytes into four held-key flags for a
// two-player paddle game (W/S for player 1, Up/Down arrows for player 2).
// Make codes set a key, F0-prefixed break codes clear it, and E0 selects the
// extended key range. A partial sequence that stalls longer than TIMEOUT
// clock cycles is abandoned.
//
// Ports:
//   CLOCK_50          in   1   system clock, rising edge
//   reset             in   1   synchronous, active-high reset
//   received_data     in   8   byte from the PS/2 receiver
//   received_data_en  in   1   one-cycle strobe qualifying received_data
//   key_held          out  4   [0] W, [1] S, [2] Up, [3] Down
//   p1_up, p1_down    out  1   player 1 paddle command
//   p2_up, p2_down    out  1   player 2 paddle command
//   key_event         out  1   pulse when any key_held bit changes
//   last_code         out 10   {extended, break, code} of last full sequence
//   timeout           out  1   pulse when a partial sequence is abandoned
// ---------------------------------------------------------------------------
module ps2_paddle_keys #(
  parameter int TIMEOUT = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic [3:0] key_held,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p2_up,
  output logic       p2_down,
  output logic       key_event,
  output logic [9:0] last_code,
  output logic       timeout
);

  // A TIMEOUT of 1 would give a zero-width counter, so keep at least one bit.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [7:0] BYTE_BREAK = 8'hF0;
  localparam logic [7:0] BYTE_EXT   = 8'hE0;
  localparam logic [7:0] CODE_W     = 8'h1D;
  localparam logic [7:0] CODE_S     = 8'h1B;
  localparam logic [7:0] CODE_UP    = 8'h75;
  localparam logic [7:0] CODE_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [3:0]      held_next;
  logic [9:0]      code_next;
  logic            timeout_next;

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Byte decoder. A received byte always takes priority over the timeout,
  // so a byte arriving on the very last allowed cycle is still decoded in
  // the current prefix context. Each non-prefix byte ends the sequence.
  always_comb begin
    state_next   = state;
    held_next    = key_held;
    code_next    = last_code;
    timeout_next = 1'b0;
    if (received_data_en) begin
      case (state)
        IDLE: begin
          if (received_data == BYTE_BREAK) begin
            state_next = BRK;
          end else if (received_data == BYTE_EXT) begin
            state_next = EXT;
          end else begin
            code_next = {2'b00, received_data};
            if (received_data == CODE_W) held_next[0] = 1'b1;
            if (received_data == CODE_S) held_next[1] = 1'b1;
          end
        end
        BRK: begin
          if (received_data == BYTE_BREAK) begin
            state_next = BRK;
          end else if (received_data == BYTE_EXT) begin
            state_next = EXT_BRK;
          end else begin
            state_next = IDLE;
            code_next  = {2'b01, received_data};
            if (received_data == CODE_W) held_next[0] = 1'b0;
            if (received_data == CODE_S) held_next[1] = 1'b0;
          end
        end
        EXT: begin
          if (received_data == BYTE_BREAK) begin
            state_next = EXT_BRK;
          end else if (received_data == BYTE_EXT) begin
            state_next = EXT;
          end else begin
            state_next = IDLE;
            code_next  = {2'b10, received_data};
            if (received_data == CODE_UP)   held_next[2] = 1'b1;
            if (received_data == CODE_DOWN) held_next[3] = 1'b1;
          end
        end
        default: begin
          if ((received_data == BYTE_BREAK) || (received_data == BYTE_EXT)) begin
            state_next = EXT_BRK;
          end else begin
            state_next = IDLE;
            code_next  = {2'b11, received_data};
            if (received_data == CODE_UP)   held_next[2] = 1'b0;
            if (received_data == CODE_DOWN) held_next[3] = 1'b0;
          end
        end
      endcase
    end else if ((state != IDLE) && (count == CNT_LAST)) begin
      state_next   = IDLE;
      timeout_next = 1'b1;
    end
  end

  // Inter-byte counter: cleared by every byte and while idle, and held at
  // its last value rather than wrapping.
  always_comb begin
    count_next = count;
    if (received_data_en || (state == IDLE)) begin
      count_next = '0;
    end else if (count != CNT_LAST) begin
      count_next = count + CW'(1);
    end
  end

  // Output registers. Paddle commands are derived from the next key state so
  // they change on the same edge as key_held; opposing keys cancel out.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count     <= '0;
      key_held  <= '0;
      p1_up     <= 1'b0;
      p1_down   <= 1'b0;
      p2_up     <= 1'b0;
      p2_down   <= 1'b0;
      key_event <= 1'b0;
      last_code <= '0;
      timeout   <= 1'b0;
    end else begin
      count     <= count_next;
      key_held  <= held_next;
      p1_up     <= held_next[0] & ~held_next[1];
      p1_down   <= held_next[1] & ~held_next[0];
      p2_up     <= held_next[2] & ~held_next[3];
      p2_down   <= held_next[3] & ~held_next[2];
      key_event <= (held_next != key_held);
      last_code <= code_next;
      timeout   <= timeout_next;
    end
  end

endmodule

// File: tb/tb_ps2_paddle_keys.sv
// ---------------------------------------------------------------------------
// tb_ps2_paddle_keys
//
// Purpose: self-checking bench for ps2_paddle_keys with TIMEOUT=16. Directed
// scenarios check fixed expected values; a randomized byte stream is checked
// every cycle against a behavioural model that tracks pending prefixes as
// two flags and the gap since the last byte as a plain integer.
// ---------------------------------------------------------------------------
module tb_ps2_paddle_keys;

  localparam int TO = 16;

  logic       clock;
  logic       reset;
  logic [7:0] received_data;
  logic       received_data_en;
  logic [3:0] key_held;
  logic       p1_up;
  logic       p1_down;
  logic       p2_up;
  logic       p2_down;
  logic       key_event;
  logic [9:0] last_code;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [3:0] m_held;
  logic [9:0] m_last;
  logic       m_event;
  logic       m_timeout;
  logic       m_ext;
  logic       m_brk;
  int         m_gap;

  ps2_paddle_keys #(.TIMEOUT(TO)) dut (
    .CLOCK_50         (clock),
    .reset            (reset),
    .received_data    (received_data),
    .received_data_en (received_data_en),
    .key_held         (key_held),
    .p1_up            (p1_up),
    .p1_down          (p1_down),
    .p2_up            (p2_up),
    .p2_down          (p2_down),
    .key_event        (key_event),
    .last_code        (last_code),
    .timeout          (timeout)
  );

  // 100 MHz-style free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [3:0] paddles(input logic [3:0] h);
    return {h[0] & ~h[1], h[1] & ~h[0], h[2] & ~h[3], h[3] & ~h[2]};
  endfunction

  // Advances the model by one clock edge, then applies the inputs to the DUT
  // and waits until just after that edge.
  task automatic step(input logic r, input logic e, input logic [7:0] d);
    logic [3:0] old;
    int idx;
    m_event   = 1'b0;
    m_timeout = 1'b0;
    if (r) begin
      m_held = '0; m_last = '0; m_ext = 1'b0; m_brk = 1'b0; m_gap = 0;
    end else if (e) begin
      m_gap = 0;
      if (d == 8'hF0) begin
        m_brk = 1'b1;
      end else if (d == 8'hE0) begin
        m_ext = 1'b1;
      end else begin
        idx = -1;
        if (!m_ext && d == 8'h1D) idx = 0;
        if (!m_ext && d == 8'h1B) idx = 1;
        if (m_ext && d == 8'h75) idx = 2;
        if (m_ext && d == 8'h72) idx = 3;
        old = m_held;
        if (idx >= 0) m_held[idx] = !m_brk;
        m_event = (old != m_held);
        m_last  = {m_ext, m_brk, d};
        m_ext   = 1'b0;
        m_brk   = 1'b0;
      end
    end else if (m_ext || m_brk) begin
      m_gap++;
      if (m_gap >= TO) begin
        m_timeout = 1'b1;
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_gap = 0;
      end
    end
    reset            = r;
    received_data_en = e;
    received_data    = d;
    @(posedge clock);
    #1;
    reset            = 1'b0;
    received_data_en = 1'b0;
  endtask

  task automatic test_reset;
    step(1'b0, 1'b1, 8'h1D);
    step(1'b0, 1'b1, 8'hF0);
    step(1'b1, 1'b1, 8'h1D);
    n_checks++;
    if ({key_held, p1_up, p1_down, p2_up, p2_down} !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_keys: got %b expected %b", {key_held, p1_up, p1_down, p2_up, p2_down}, 8'h00);
    end
    n_checks++;
    if ({key_event, timeout, last_code} !== 12'h000) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: got %h expected %h", {key_event, timeout, last_code}, 12'h000);
    end
    step(1'b0, 1'b1, 8'h1D);
    n_checks++;
    if (key_held !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL reset_state_idle: got %b expected %b", key_held, 4'b0001);
    end
  endtask

  task automatic test_w_make_break;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h1D);
    n_checks++;
    if ({key_held, p1_up, key_event, last_code} !== {4'b0001, 1'b1, 1'b1, 10'h01D}) begin
      n_fail++;
      $display("[TB] FAIL w_make: got held=%b p1_up=%b ev=%b code=%h expected 0001 1 1 01d",
               key_held, p1_up, key_event, last_code);
    end
    step(1'b0, 1'b1, 8'hF0);
    n_checks++;
    if ({key_held, key_event, last_code} !== {4'b0001, 1'b0, 10'h01D}) begin
      n_fail++;
      $display("[TB] FAIL w_prefix: got held=%b ev=%b code=%h expected 0001 0 01d", key_held, key_event, last_code);
    end
    step(1'b0, 1'b1, 8'h1D);
    n_checks++;
    if ({key_held, p1_up, key_event, last_code} !== {4'b0000, 1'b0, 1'b1, 10'h11D}) begin
      n_fail++;
      $display("[TB] FAIL w_break: got held=%b p1_up=%b ev=%b code=%h expected 0000 0 1 11d",
               key_held, p1_up, key_event, last_code);
    end
  endtask

  task automatic test_ext_up;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hE0);
    step(1'b0, 1'b1, 8'h75);
    n_checks++;
    if ({key_held, p2_up, p2_down, last_code} !== {4'b0100, 1'b1, 1'b0, 10'h275}) begin
      n_fail++;
      $display("[TB] FAIL up_make: got held=%b p2_up=%b p2_down=%b code=%h expected 0100 1 0 275",
               key_held, p2_up, p2_down, last_code);
    end
    step(1'b0, 1'b1, 8'hE0);
    step(1'b0, 1'b1, 8'hF0);
    step(1'b0, 1'b1, 8'h75);
    n_checks++;
    if ({key_held, p2_up, key_event, last_code} !== {4'b0000, 1'b0, 1'b1, 10'h375}) begin
      n_fail++;
      $display("[TB] FAIL up_break: got held=%b p2_up=%b ev=%b code=%h expected 0000 0 1 375",
               key_held, p2_up, key_event, last_code);
    end
  endtask

  task automatic test_both_keys;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h1D);
    step(1'b0, 1'b1, 8'h1B);
    n_checks++;
    if ({key_held, p1_up, p1_down} !== {4'b0011, 1'b0, 1'b0}) begin
      n_fail++;
      $display("[TB] FAIL both_cancel: got held=%b p1_up=%b p1_down=%b expected 0011 0 0", key_held, p1_up, p1_down);
    end
    step(1'b0, 1'b1, 8'hF0);
    step(1'b0, 1'b1, 8'h1D);
    n_checks++;
    if ({key_held, p1_up, p1_down} !== {4'b0010, 1'b0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL s_only: got held=%b p1_up=%b p1_down=%b expected 0010 0 1", key_held, p1_up, p1_down);
    end
  endtask

  task automatic test_timeout;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hF0);
    for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 8'h00);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL timeout_early: got %b expected 0", timeout);
    end
    step(1'b0, 1'b0, 8'h00);
    n_checks++;
    if ({timeout, key_held} !== {1'b1, 4'b0000}) begin
      n_fail++;
      $display("[TB] FAIL timeout_pulse: got to=%b held=%b expected 1 0000", timeout, key_held);
    end
    step(1'b0, 1'b0, 8'h00);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL timeout_once: got %b expected 0", timeout);
    end
    step(1'b0, 1'b1, 8'h1D);
    n_checks++;
    if ({key_held, last_code} !== {4'b0001, 10'h01D}) begin
      n_fail++;
      $display("[TB] FAIL after_timeout_make: got held=%b code=%h expected 0001 01d", key_held, last_code);
    end
    // A byte on the final allowed cycle is decoded as a break, no timeout.
    step(1'b0, 1'b1, 8'hF0);
    for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h1D);
    n_checks++;
    if ({timeout, key_held, key_event, last_code} !== {1'b0, 4'b0000, 1'b1, 10'h11D}) begin
      n_fail++;
      $display("[TB] FAIL byte_wins: got to=%b held=%b ev=%b code=%h expected 0 0000 1 11d",
               timeout, key_held, key_event, last_code);
    end
  endtask

  task automatic test_reset_midseq;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'hE0);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h75);
    n_checks++;
    if ({key_held, key_event, last_code} !== {4'b0000, 1'b0, 10'h075}) begin
      n_fail++;
      $display("[TB] FAIL reset_midseq: got held=%b ev=%b code=%h expected 0000 0 075", key_held, key_event, last_code);
    end
  endtask

  task automatic test_repeat_make;
    logic [2:0] ev;
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h1D);
      ev[i] = key_event;
    end
    n_checks++;
    if (ev !== 3'b001) begin
      n_fail++;
      $display("[TB] FAIL repeat_events: got %b expected 001", ev);
    end
    step(1'b0, 1'b1, 8'h1C);
    n_checks++;
    if ({key_held, key_event, last_code} !== {4'b0001, 1'b0, 10'h01C}) begin
      n_fail++;
      $display("[TB] FAIL other_code: got held=%b ev=%b code=%h expected 0001 0 01c", key_held, key_event, last_code);
    end
  endtask

  task automatic test_random;
    logic       r;
    logic       e;
    logic [7:0] d;
    int         idle_left;
    logic [19:0] obs;
    logic [19:0] exp;
    idle_left = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      r = 1'b0;
      e = 1'b0;
      d = 8'h00;
      if (idle_left > 0) begin
        idle_left--;
      end else begin
        case ($urandom_range(0, 9))
          0, 1:    d = 8'h1D;
          2:       d = 8'h1B;
          3:       d = 8'h75;
          4:       d = 8'h72;
          5, 6:    d = 8'hF0;
          7, 8:    d = 8'hE0;
          default: d = 8'($urandom_range(0, 255));
        endcase
        e = 1'b1;
        if ($urandom_range(0, 80) == 0) r = 1'b1;
        if ($urandom_range(0, 7) == 0) idle_left = $urandom_range(TO - 3, TO + 3);
        else idle_left = $urandom_range(0, 2);
      end
      step(r, e, d);
      obs = {key_held, p1_up, p1_down, p2_up, p2_down, key_event, timeout, last_code};
      exp = {m_held, paddles(m_held), m_event, m_timeout, m_last};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("[TB] FAIL random cyc=%0d: got held=%b pad=%b ev=%b to=%b code=%h expected held=%b pad=%b ev=%b to=%b code=%h",
                 cyc, obs[19:16], obs[15:12], obs[11], obs[10], obs[9:0],
                 exp[19:16], exp[15:12], exp[11], exp[10], exp[9:0]);
      end
    end
  endtask

  initial begin
    reset            = 1'b1;
    received_data_en = 1'b0;
    received_data    = 8'h00;
    m_held = '0; m_last = '0; m_event = 1'b0; m_timeout = 1'b0;
    m_ext = 1'b0; m_brk = 1'b0; m_gap = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    $display("[TB] starting ps2_paddle_keys bench");
    test_reset();
    test_w_make_break();
    test_ext_up();
    test_both_keys();
    test_timeout();
    test_reset_midseq();
    test_repeat_make();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
